// File: rtl/apb_led_pwm.sv
// APB3 slave driving NUM_CH LED PWM channels from a shared, prescaled period counter.
// Period and duty writes land in shadow registers and reach the active copies only on a wrap.
module apb_led_pwm #(
  parameter int NUM_CH = 8,
  parameter int CNT_W  = 8
) (
  input  logic              io_systemClk,
  input  logic              io_asyncResetn,
  input  logic [15:0]       PADDR,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERROR,
  output logic [NUM_CH-1:0] pwm_out
);

  localparam logic [13:0] W_CTRL  = 14'd0;
  localparam logic [13:0] W_PRESC = 14'd1;
  localparam logic [13:0] W_PER   = 14'd2;
  localparam logic [13:0] W_STAT  = 14'd3;
  localparam logic [13:0] W_DUTY0 = 14'd4;

  logic [13:0]                  word;
  logic                         access;
  logic                         mapped;
  logic                         we;
  logic [31:0]                  rdata;
  logic [NUM_CH-1:0]            duty_hit;

  logic                         ready_q, ready_d;
  logic [1:0]                   ctrl_q, ctrl_d;
  logic [15:0]                  presc_q, presc_d;
  logic [CNT_W-1:0]             per_sh_q, per_sh_d;
  logic [CNT_W-1:0]             per_act_q, per_act_d;
  logic [NUM_CH-1:0][CNT_W-1:0] duty_sh_q, duty_sh_d;
  logic [NUM_CH-1:0][CNT_W-1:0] duty_act_q, duty_act_d;
  logic                         wrap_flag_q, wrap_flag_d;
  logic [15:0]                  pc_q, pc_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [NUM_CH-1:0]            pwm_q, pwm_d;

  logic                         en;
  logic                         inv;
  logic                         tick;
  logic                         wrap;
  logic                         load;
  logic                         unused_bits;

  assign unused_bits = ^{PADDR[1:0], PWDATA[31:16]};
  assign word        = PADDR[15:2];
  assign access      = PSEL & PENABLE;
  // PREADY is qualified by the live handshake so it drops as soon as the master lets go.
  assign PREADY      = ready_q & access;
  assign PRDATA      = PREADY ? rdata : 32'd0;
  assign PSLVERROR   = PREADY & ~mapped;
  assign we          = PREADY & PWRITE & mapped;
  assign pwm_out     = pwm_q;

  always_comb begin
    rdata    = 32'd0;
    duty_hit = '0;
    case (word)
      W_CTRL:  rdata = {30'd0, ctrl_q};
      W_PRESC: rdata = {16'd0, presc_q};
      W_PER:   rdata = 32'(per_sh_q);
      W_STAT:  rdata = {31'd0, wrap_flag_q};
      default: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (word == W_DUTY0 + 14'(i)) begin
            duty_hit[i] = 1'b1;
            rdata       = 32'(duty_sh_q[i]);
          end
        end
      end
    endcase
    mapped = (word < W_DUTY0) | (|duty_hit);
  end

  always_comb begin
    ready_d   = access & ~ready_q;
    ctrl_d    = ctrl_q;
    presc_d   = presc_q;
    per_sh_d  = per_sh_q;
    duty_sh_d = duty_sh_q;
    if (we) begin
      if (word == W_CTRL)  ctrl_d   = PWDATA[1:0];
      if (word == W_PRESC) presc_d  = PWDATA[15:0];
      if (word == W_PER)   per_sh_d = PWDATA[CNT_W-1:0];
      for (int i = 0; i < NUM_CH; i++) begin
        if (duty_hit[i]) duty_sh_d[i] = PWDATA[CNT_W-1:0];
      end
    end
    // A wrap in the same cycle as a write-1-to-clear keeps the flag set.
    wrap_flag_d = wrap | (wrap_flag_q & ~(we & (word == W_STAT) & PWDATA[0]));
  end

  assign en   = ctrl_q[0];
  assign inv  = ctrl_q[1];
  assign tick = en & (pc_q == presc_q);
  assign wrap = tick & (cnt_q == per_act_q);
  assign load = wrap | ~en;

  always_comb begin
    pc_d = pc_q + 16'd1;
    if (!en || tick) pc_d = 16'd0;

    cnt_d = cnt_q;
    if (!en || wrap)  cnt_d = '0;
    else if (tick)    cnt_d = cnt_q + CNT_W'(1);

    per_act_d  = load ? per_sh_q  : per_act_q;
    duty_act_d = load ? duty_sh_q : duty_act_q;

    for (int i = 0; i < NUM_CH; i++) begin
      pwm_d[i] = en ? ((cnt_q < duty_act_q[i]) ^ inv) : inv;
    end
  end

  always_ff @(posedge io_systemClk or negedge io_asyncResetn) begin
    if (!io_asyncResetn) begin
      ready_q     <= 1'b0;
      ctrl_q      <= 2'd0;
      presc_q     <= 16'd0;
      per_sh_q    <= '1;
      per_act_q   <= '1;
      duty_sh_q   <= '0;
      duty_act_q  <= '0;
      wrap_flag_q <= 1'b0;
      pc_q        <= 16'd0;
      cnt_q       <= '0;
      pwm_q       <= '0;
    end else begin
      ready_q     <= ready_d;
      ctrl_q      <= ctrl_d;
      presc_q     <= presc_d;
      per_sh_q    <= per_sh_d;
      per_act_q   <= per_act_d;
      duty_sh_q   <= duty_sh_d;
      duty_act_q  <= duty_act_d;
      wrap_flag_q <= wrap_flag_d;
      pc_q        <= pc_d;
      cnt_q       <= cnt_d;
      pwm_q       <= pwm_d;
    end
  end

endmodule

// File: tb/tb_apb_led_pwm.sv
// Bench for apb_led_pwm: register-file model plus closed-form PWM waveform prediction
// (tick count / period arithmetic) under directed and $urandom configurations.
module tb_apb_led_pwm;

  localparam int NUM_CH = 8;
  localparam int CNT_W  = 8;

  localparam logic [15:0] A_CTRL  = 16'h0000;
  localparam logic [15:0] A_PRESC = 16'h0004;
  localparam logic [15:0] A_PER   = 16'h0008;
  localparam logic [15:0] A_STAT  = 16'h000C;
  localparam logic [15:0] A_DUTY  = 16'h0010;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [15:0]       PADDR = 16'h0;
  logic              PSEL = 1'b0;
  logic              PENABLE = 1'b0;
  logic              PWRITE = 1'b0;
  logic [31:0]       PWDATA = 32'h0;
  logic [31:0]       PRDATA;
  logic              PREADY;
  logic              PSLVERROR;
  logic [NUM_CH-1:0] pwm_out;

  apb_led_pwm #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .io_systemClk  (clk),
    .io_asyncResetn(rst_n),
    .PADDR         (PADDR),
    .PSEL          (PSEL),
    .PENABLE       (PENABLE),
    .PWRITE        (PWRITE),
    .PWDATA        (PWDATA),
    .PRDATA        (PRDATA),
    .PREADY        (PREADY),
    .PSLVERROR     (PSLVERROR),
    .pwm_out       (pwm_out)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Register-file model
  logic [1:0]       m_ctrl;
  logic [15:0]      m_presc;
  logic [CNT_W-1:0] m_per;
  logic             m_wrap;
  logic [CNT_W-1:0] m_duty [NUM_CH];

  task automatic model_reset();
    m_ctrl  = 2'd0;
    m_presc = 16'd0;
    m_per   = '1;
    m_wrap  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) m_duty[i] = '0;
  endtask

  function automatic bit model_mapped(input logic [15:0] a);
    return int'(a[15:2]) < 4 + NUM_CH;
  endfunction

  function automatic logic [31:0] model_val(input logic [15:0] a);
    int w;
    w = int'(a[15:2]);
    if (w == 0) return 32'(m_ctrl);
    if (w == 1) return 32'(m_presc);
    if (w == 2) return 32'(m_per);
    if (w == 3) return 32'(m_wrap);
    if (w < 4 + NUM_CH) return 32'(m_duty[w-4]);
    return 32'd0;
  endfunction

  // Expected pwm_out k clocks after the enabling write commits: after k rising
  // edges the output reflects the count reached after k-1 edges, and with one
  // tick per PRESC+1 clocks that count is ((k-1)/(p+1)) mod (n+1).
  function automatic logic [NUM_CH-1:0] exp_pwm(input int k, input int p, input int n, input bit inv);
    logic [NUM_CH-1:0] r;
    int c;
    if (k == 0) return {NUM_CH{inv}};
    c = ((k - 1) / (p + 1)) % (n + 1);
    for (int ch = 0; ch < NUM_CH; ch++) r[ch] = (c < int'(m_duty[ch])) ^ inv;
    return r;
  endfunction

  task automatic apb(input logic [15:0] addr, input bit wr, input logic [31:0] wd,
                     output logic [31:0] rd, output logic err);
    int waits;
    @(negedge clk);
    PADDR = addr; PWRITE = wr; PWDATA = wd; PSEL = 1'b1; PENABLE = 1'b0;
    @(negedge clk);
    PENABLE = 1'b1;
    #1;
    chk("wait_state", 32'(PREADY), 32'd0);
    @(negedge clk);
    waits = 0;
    while (PREADY !== 1'b1 && waits < 4) begin
      @(negedge clk);
      waits++;
    end
    chk("extra_waits", 32'(waits), 32'd0);
    chk("pready", 32'(PREADY), 32'd1);
    rd  = PRDATA;
    err = PSLVERROR;
    @(posedge clk);
    #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic reg_access(input logic [15:0] addr, input bit wr, input logic [31:0] wd,
                            input bit skip_status);
    logic [31:0] rd;
    logic [31:0] exp_rd;
    logic        err;
    bit          mp;
    int          w;
    w      = int'(addr[15:2]);
    mp     = model_mapped(addr);
    exp_rd = model_val(addr);
    apb(addr, wr, wd, rd, err);
    $display("apb %s addr=0x%04h wdata=0x%08h rdata=0x%08h err=%0d", wr ? "WR" : "RD",
             addr, wd, rd, err);
    chk($sformatf("err_%04h", addr), 32'(err), 32'(!mp));
    if (!mp || (!wr && !(skip_status && w == 3)))
      chk($sformatf("rdata_%04h", addr), rd, exp_rd);
    if (wr && mp) begin
      if (w == 0) m_ctrl = wd[1:0];
      else if (w == 1) m_presc = wd[15:0];
      else if (w == 2) m_per = wd[CNT_W-1:0];
      else if (w == 3) begin if (wd[0]) m_wrap = 1'b0; end
      else m_duty[w-4] = wd[CNT_W-1:0];
    end
  endtask

  task automatic read_all(input bit skip_status);
    reg_access(A_CTRL, 1'b0, 32'd0, skip_status);
    reg_access(A_PRESC, 1'b0, 32'd0, skip_status);
    reg_access(A_PER, 1'b0, 32'd0, skip_status);
    reg_access(A_STAT, 1'b0, 32'd0, skip_status);
    for (int i = 0; i < NUM_CH; i++) reg_access(A_DUTY + 16'(4*i), 1'b0, 32'd0, skip_status);
  endtask

  task automatic run_pwm(input int p, input int n, input bit inv, input int ncyc);
    reg_access(A_CTRL, 1'b1, {30'd0, inv, 1'b0}, 1'b1);
    reg_access(A_PRESC, 1'b1, 32'(p), 1'b1);
    reg_access(A_PER, 1'b1, 32'(n), 1'b1);
    reg_access(A_CTRL, 1'b1, {30'd0, inv, 1'b1}, 1'b1);
    for (int k = 0; k <= ncyc; k++) begin
      @(negedge clk);
      chk($sformatf("pwm_p%0d_n%0d_k%0d", p, n, k), 32'(pwm_out), 32'(exp_pwm(k, p, n, inv)));
    end
    $display("pwm run presc=%0d period=%0d inv=%0d cycles=%0d", p, n, inv, ncyc);
  endtask

  // Per-period high-time counters for the mid-period duty update
  bit     meas = 1'b0;
  longint c0 = 0;
  int     hi0 = 0;
  int     hi1 = 0;
  int     oth = 0;
  always @(negedge clk) begin
    if (meas) begin
      if (cyc - c0 >= 1 && cyc - c0 <= 256) hi0 <= hi0 + int'(pwm_out[0]);
      else if (cyc - c0 >= 257 && cyc - c0 <= 512) hi1 <= hi1 + int'(pwm_out[0]);
      if (pwm_out[NUM_CH-1:1] != '0) oth <= oth + 1;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    int n;
    bit inv;
    model_reset();
    // Reset held with a live handshake on the bus
    PSEL = 1'b1; PENABLE = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_pready", 32'(PREADY), 32'd0);
    chk("reset_pslverr", 32'(PSLVERROR), 32'd0);
    chk("reset_prdata", PRDATA, 32'd0);
    chk("reset_pwm", 32'(pwm_out), 32'd0);
    PSEL = 1'b0; PENABLE = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    read_all(1'b0);

    // 64/256 duty, then a mid-period update to 128 taking effect next period
    reg_access(A_DUTY, 1'b1, 32'h40, 1'b1);
    reg_access(A_PRESC, 1'b1, 32'd0, 1'b1);
    reg_access(A_PER, 1'b1, 32'hFF, 1'b1);
    reg_access(A_CTRL, 1'b1, 32'd1, 1'b1);
    c0 = cyc;
    meas = 1'b1;
    repeat (100) @(negedge clk);
    reg_access(A_DUTY, 1'b1, 32'h80, 1'b1);
    for (int i = 0; i < 600 && cyc < c0 + 514; i++) @(negedge clk);
    meas = 1'b0;
    chk("high_period0", 32'(hi0), 32'd64);
    chk("high_period1", 32'(hi1), 32'd128);
    chk("other_channels", 32'(oth), 32'd0);

    // Unmapped accesses: error, zero data, no side effects
    reg_access(16'h0200, 1'b0, 32'd0, 1'b1);
    reg_access(16'h0200, 1'b1, 32'hFFFF_FFFF, 1'b1);
    reg_access(A_DUTY + 16'(4*NUM_CH), 1'b1, 32'h5A, 1'b1);
    read_all(1'b1);

    // Random register traffic
    for (int i = 0; i < 30; i++) begin
      logic [15:0] a;
      if ($urandom_range(0, 9) == 0) a = 16'h0200;
      else a = 16'($urandom_range(0, NUM_CH + 5) * 4 + $urandom_range(0, 3));
      reg_access(a, 1'($urandom_range(0, 1)), $urandom, 1'b1);
    end

    // PRESC=3, PERIOD=3, DUTY[1]=2: 8 high / 8 low
    for (int i = 0; i < NUM_CH; i++)
      reg_access(A_DUTY + 16'(4*i), 1'b1, (i == 1) ? 32'd2 : 32'd0, 1'b1);
    run_pwm(3, 3, 1'b0, 40);
    m_wrap = 1'b1;
    reg_access(A_STAT, 1'b0, 32'd0, 1'b0);
    reg_access(A_CTRL, 1'b1, 32'd0, 1'b1);
    reg_access(A_STAT, 1'b1, 32'd1, 1'b1);
    reg_access(A_STAT, 1'b0, 32'd0, 1'b0);
    // Wrap every clock: clearing write collides with a wrap and loses
    reg_access(A_PRESC, 1'b1, 32'd0, 1'b1);
    reg_access(A_PER, 1'b1, 32'd0, 1'b1);
    reg_access(A_CTRL, 1'b1, 32'd1, 1'b1);
    reg_access(A_STAT, 1'b1, 32'd1, 1'b1);
    m_wrap = 1'b1;
    reg_access(A_STAT, 1'b0, 32'd0, 1'b0);

    // Random configurations (includes PERIOD=0 and DUTY>PERIOD)
    for (int r = 0; r < 6; r++) begin
      p   = int'($urandom_range(0, 3));
      n   = (r == 0) ? 0 : int'($urandom_range(0, 15));
      inv = 1'($urandom_range(0, 1));
      for (int i = 0; i < NUM_CH; i++)
        reg_access(A_DUTY + 16'(4*i), 1'b1, 32'($urandom_range(0, n + 2)), 1'b1);
      run_pwm(p, n, inv, 2 * (p + 1) * (n + 1) + 4);
      m_wrap = 1'b1;
      reg_access(A_STAT, 1'b0, 32'd0, 1'b0);
    end

    // EN+INV with zero duty, then INV only
    for (int i = 0; i < NUM_CH; i++) reg_access(A_DUTY + 16'(4*i), 1'b1, 32'd0, 1'b1);
    run_pwm(1, 5, 1'b1, 20);
    reg_access(A_CTRL, 1'b1, 32'd2, 1'b1);
    repeat (3) @(negedge clk);
    chk("inv_only_pwm", 32'(pwm_out), 32'({NUM_CH{1'b1}}));

    // Reset pulsed while a write is in its completion cycle
    @(negedge clk);
    PADDR = A_PRESC; PWRITE = 1'b1; PWDATA = 32'h1234; PSEL = 1'b1; PENABLE = 1'b0;
    @(negedge clk);
    PENABLE = 1'b1;
    @(negedge clk);
    chk("midxfer_pready_before", 32'(PREADY), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("midxfer_pready", 32'(PREADY), 32'd0);
    chk("midxfer_pslverr", 32'(PSLVERROR), 32'd0);
    chk("midxfer_prdata", PRDATA, 32'd0);
    chk("midxfer_pwm", 32'(pwm_out), 32'd0);
    $display("async reset pulsed mid-transfer");
    PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    read_all(1'b0);
    run_pwm(0, 3, 1'b0, 12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
